// File: rtl/robot_cpu_pkg.sv
// Shared opcode and FSM state types for the robot sequencer core.
package robot_cpu_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_WAIT = 3'd0,
    OP_OUT  = 3'd1,
    OP_JMP  = 3'd2,
    OP_JSET = 3'd3,
    OP_JCLR = 3'd4,
    OP_SEL  = 3'd5,
    OP_CALL = 3'd6,
    OP_RET  = 3'd7
  } op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/robot_wait_timer.sv
// Wait timer: a PRESCALE-cycle tick divider feeding a down-counter.
// done pulses on the edge that consumes the final tick.
module robot_wait_timer #(
  parameter int WAIT_W   = 8,
  parameter int PRESCALE = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [WAIT_W-1:0] n,
  output logic              done
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TW-1:0] TMAX = TW'(PRESCALE - 1);

  logic [TW-1:0]     tick_q, tick_d;
  logic [WAIT_W-1:0] rem_q, rem_d;

  always_comb begin
    tick_d = tick_q;
    rem_d  = rem_q;
    done   = 1'b0;
    if (enable) begin
      if (start) begin
        tick_d = '0;
        rem_d  = n;
      end else if (rem_q != '0) begin
        if (tick_q == TMAX) begin
          tick_d = '0;
          rem_d  = rem_q - 1'b1;
          done   = (rem_q == WAIT_W'(1));
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      rem_q  <= '0;
    end else begin
      tick_q <= tick_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/robot_cpu_core_p.sv
// Robot sequencer core: one instruction per cycle from an async ROM.
// Define SENSOR_SYNC_EN to add a 2-flop synchroniser on SENSOR.
module robot_cpu_core_p
  import robot_cpu_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int OP_W     = 8,
  parameter int SENSOR_N = 4,
  parameter int MOTOR_N  = 4,
  parameter int WAIT_W   = 8,
  parameter int PRESCALE = 256
) (
  input  logic                 CLK,
  input  logic                 RESET_LOW,
  input  logic                 ENABLE,
  input  logic [SENSOR_N-1:0]  SENSOR,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  input  logic [OPC_W+OP_W-1:0] MEM_DATA,
  output logic [MOTOR_N-1:0]   MOTOR,
  output logic                 WAIT_BUSY,
  output logic                 PC_WRAP
);

  localparam int SW = (SENSOR_N > 1) ? $clog2(SENSOR_N) : 1;

  logic [ADDR_W-1:0]  pc_q, pc_d, link_q, link_d, pc_inc;
  logic [MOTOR_N-1:0] motor_q, motor_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic               lv_q, lv_d;
  logic               wrap_q, wrap_d;
  state_e             state_q, state_d;

  logic [SENSOR_N-1:0] sens;
  logic [OP_W-1:0]     operand;
  logic [ADDR_W-1:0]   tgt;
  op_e                 op;
  logic                s_bit, adv, t_start, t_done;

`ifdef SENSOR_SYNC_EN
  logic [SENSOR_N-1:0] s1_q, s2_q;

  always_ff @(posedge CLK or negedge RESET_LOW) begin
    if (!RESET_LOW) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= SENSOR;
      s2_q <= s1_q;
    end
  end

  assign sens = s2_q;
`else
  assign sens = SENSOR;
`endif

  assign op      = op_e'(MEM_DATA[OP_W+OPC_W-1:OP_W]);
  assign operand = MEM_DATA[OP_W-1:0];
  assign tgt     = operand[ADDR_W-1:0];
  assign pc_inc  = pc_q + 1'b1;
  assign s_bit   = sens[sel_q];

  robot_wait_timer #(
    .WAIT_W  (WAIT_W),
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk   (CLK),
    .rst_n (RESET_LOW),
    .enable(ENABLE),
    .start (t_start),
    .n     (operand[WAIT_W-1:0]),
    .done  (t_done)
  );

  always_comb begin
    pc_d    = pc_q;
    motor_d = motor_q;
    sel_d   = sel_q;
    link_d  = link_q;
    lv_d    = lv_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    t_start = 1'b0;
    adv     = 1'b0;
    if (ENABLE) begin
      unique case (state_q)
        ST_WAIT: begin
          if (t_done) begin
            state_d = ST_RUN;
            adv     = 1'b1;
          end
        end
        ST_RUN: begin
          unique case (op)
            OP_WAIT: begin
              if (operand[WAIT_W-1:0] != '0) begin
                state_d = ST_WAIT;
                t_start = 1'b1;
              end else begin
                adv = 1'b1;
              end
            end
            OP_OUT: begin
              motor_d = operand[MOTOR_N-1:0];
              adv     = 1'b1;
            end
            OP_JMP:  pc_d = tgt;
            OP_JSET: if (s_bit) pc_d = tgt; else adv = 1'b1;
            OP_JCLR: if (!s_bit) pc_d = tgt; else adv = 1'b1;
            OP_SEL: begin
              // out-of-range selects fall back to sensor 0
              sel_d = (operand < OP_W'(SENSOR_N)) ? operand[SW-1:0] : '0;
              adv   = 1'b1;
            end
            OP_CALL: begin
              link_d = pc_inc;
              lv_d   = 1'b1;
              pc_d   = tgt;
            end
            OP_RET: begin
              if (lv_q) begin
                pc_d = link_q;
                lv_d = 1'b0;
              end else begin
                adv = 1'b1;
              end
            end
          endcase
        end
      endcase
      if (adv) begin
        pc_d   = pc_inc;
        wrap_d = (pc_q == '1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_LOW) begin
    if (!RESET_LOW) begin
      pc_q    <= '0;
      motor_q <= '0;
      sel_q   <= '0;
      link_q  <= '0;
      lv_q    <= 1'b0;
      wrap_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      motor_q <= motor_d;
      sel_q   <= sel_d;
      link_q  <= link_d;
      lv_q    <= lv_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
    end
  end

  assign MEM_ADDR  = pc_q;
  assign MOTOR     = motor_q;
  assign WAIT_BUSY = (state_q == ST_WAIT);
  assign PC_WRAP   = wrap_q & ENABLE;

endmodule

// File: tb/tb_robot_cpu_core_p.sv
// Scoreboard bench for robot_cpu_core_p with PRESCALE=4, ADDR_W=6.
module tb_robot_cpu_core_p;

  logic        CLK = 1'b0;
  logic        RESET_LOW = 1'b0;
  logic        ENABLE = 1'b1;
  logic [3:0]  SENSOR = '0;
  logic [5:0]  MEM_ADDR;
  logic [10:0] MEM_DATA;
  logic [3:0]  MOTOR;
  logic        WAIT_BUSY;
  logic        PC_WRAP;

  logic [10:0] rom [64];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string tag;
    int    pc;
    int    mot;
    int    busy;
    int    wrap;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  assign MEM_DATA = rom[MEM_ADDR];

  robot_cpu_core_p #(
    .ADDR_W(6), .OP_W(8), .SENSOR_N(4),
    .MOTOR_N(4), .WAIT_W(8), .PRESCALE(4)
  ) dut (
    .CLK(CLK), .RESET_LOW(RESET_LOW), .ENABLE(ENABLE),
    .SENSOR(SENSOR), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .MOTOR(MOTOR), .WAIT_BUSY(WAIT_BUSY), .PC_WRAP(PC_WRAP)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ins(input logic [31:0] op,
                                      input logic [31:0] arg);
    return {op[2:0], arg[7:0]};
  endfunction

  task automatic clr_rom();
    foreach (rom[i]) rom[i] = '0;
  endtask

  task automatic push(input string tag, input int pc, input int mot,
                      input int busy, input int wrap);
    exp_t e;
    e.tag = tag; e.pc = pc; e.mot = mot; e.busy = busy; e.wrap = wrap;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
        check("sb_underflow", 0, 1);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_pc"},   32'(MEM_ADDR),  e.pc);
        check({e.tag, "_mot"},  32'(MOTOR),     e.mot);
        check({e.tag, "_busy"}, 32'(WAIT_BUSY), e.busy);
        check({e.tag, "_wrap"}, 32'(PC_WRAP),   e.wrap);
      end
    end
  endtask

  task automatic rst();
    @(negedge CLK);
    RESET_LOW = 1'b0;
    ENABLE = 1'b1;
    @(negedge CLK);
    RESET_LOW = 1'b1;
  endtask

  task automatic cond_prog(input int op, input int s, input int sens,
                           input int tgt2, input string tag);
    clr_rom();
    rom[2] = ins(5, s);
    rom[3] = ins(op, 32'h20);
    SENSOR = sens[3:0];
    rst();
    push({tag, "_n0"}, 1, 0, 0, 0);
    push({tag, "_n1"}, 2, 0, 0, 0);
    push({tag, "_sel"}, 3, 0, 0, 0);
    push({tag, "_j"}, tgt2, 0, 0, 0);
    step(4);
  endtask

  initial begin
    clr_rom();
    repeat (2) @(negedge CLK);
    check("rst_pc", 32'(MEM_ADDR), 0);
    check("rst_mot", 32'(MOTOR), 0);
    check("rst_busy", 32'(WAIT_BUSY), 0);
    check("rst_wrap", 32'(PC_WRAP), 0);

    // timing: OUT 1010, WAIT 3, WAIT 0, JMP 3
    rom[0] = ins(1, 4'b1010);
    rom[1] = ins(0, 3);
    rom[2] = ins(0, 0);
    rom[3] = ins(2, 3);
    rst();
    push("t_out", 1, 10, 0, 0);
    for (int i = 0; i < 12; i++) push("t_wait", 1, 10, 1, 0);
    push("t_done", 2, 10, 0, 0);
    push("t_w0", 3, 10, 0, 0);
    push("t_jmp", 3, 10, 0, 0);
    step(16);

    // pause for 10 cycles in the middle of WAIT 3
    rst();
    push("p_out", 1, 10, 0, 0);
    for (int i = 0; i < 5; i++) push("p_w", 1, 10, 1, 0);
    step(6);
    ENABLE = 1'b0;
    for (int i = 0; i < 10; i++) push("p_hold", 1, 10, 1, 0);
    step(10);
    ENABLE = 1'b1;
    for (int i = 0; i < 7; i++) push("p_w2", 1, 10, 1, 0);
    push("p_done", 2, 10, 0, 0);
    step(8);

    // asynchronous reset during WAIT 5
    clr_rom();
    rom[0] = ins(1, 4'hF);
    rom[1] = ins(0, 5);
    rst();
    push("r_out", 1, 15, 0, 0);
    for (int i = 0; i < 4; i++) push("r_w", 1, 15, 1, 0);
    step(5);
    RESET_LOW = 1'b0;
    #1;
    check("rw_pc", 32'(MEM_ADDR), 0);
    check("rw_mot", 32'(MOTOR), 0);
    check("rw_busy", 32'(WAIT_BUSY), 0);

    // conditional jumps
    cond_prog(3, 2, 4'b0100, 32'h20, "jset1");
    cond_prog(3, 2, 4'b0000, 4, "jset0");
    cond_prog(4, 2, 4'b0100, 4, "jclr1");
    cond_prog(4, 2, 4'b0000, 32'h20, "jclr0");
    cond_prog(3, 7, 4'b0001, 32'h20, "sel7a");
    cond_prog(3, 7, 4'b1000, 4, "sel7b");
    SENSOR = '0;

    // call / return
    clr_rom();
    rom[0]     = ins(2, 5);
    rom[5]     = ins(6, 32'h10);
    rom[32'h10] = ins(7, 0);
    rom[6]     = ins(7, 0);
    rom[7]     = ins(6, 32'h20);
    rom[32'h20] = ins(6, 32'h30);
    rom[32'h30] = ins(7, 0);
    rom[32'h21] = ins(7, 0);
    rst();
    push("c_jmp", 5, 0, 0, 0);
    push("c_call", 32'h10, 0, 0, 0);
    push("c_ret", 6, 0, 0, 0);
    push("c_ret2", 7, 0, 0, 0);
    push("c_call2", 32'h20, 0, 0, 0);
    push("c_call3", 32'h30, 0, 0, 0);
    push("c_ret3", 32'h21, 0, 0, 0);
    push("c_ret4", 32'h22, 0, 0, 0);
    step(8);

    // PC wrap at 63 -> 0
    clr_rom();
    rom[0] = ins(2, 62);
    rst();
    push("w_jmp", 62, 0, 0, 0);
    push("w_62", 63, 0, 0, 0);
    push("w_wrap", 0, 0, 0, 1);
    push("w_after", 62, 0, 0, 0);
    step(4);

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/robot_cpu_core_p.md
Name: robot_cpu_core_p

Overview:
Parametrised next-generation robot sequencer core. Fetches from an asynchronous-read program ROM and executes a 3-bit-opcode instruction set. The set covers motor output, prescaled wait, unconditional and sensor-conditional jumps, sensor select, and a single-level call/return. Sits between program ROM, sensor inputs and motor drivers; replaces the fixed 4-address, 2-motor, 2-sensor core.

Parameters:
ADDR_W, 6, program counter / ROM address width (ROM depth 2^ADDR_W)
OP_W, 8, operand width; must be >= ADDR_W, MOTOR_N, WAIT_W and clog2(SENSOR_N)
SENSOR_N, 4, number of sensor inputs
MOTOR_N, 4, number of motor output bits
WAIT_W, 8, wait-count operand width
PRESCALE, 256, clock cycles per wait tick (>=1)

Ports:
CLK  in  1  clock, rising edge
RESET_LOW  in  1  asynchronous, active-low reset
ENABLE  in  1  1 = run; 0 = freeze all state
SENSOR  in  SENSOR_N  sensor levels, 1 = active
MEM_ADDR  out  ADDR_W  ROM address (= PC)
MEM_DATA  in  3+OP_W  instruction at MEM_ADDR, same cycle; [OP_W+2:OP_W] opcode, [OP_W-1:0] operand
MOTOR  out  MOTOR_N  registered motor drive
WAIT_BUSY  out  1  1 while in WAIT state
PC_WRAP  out  1  one-cycle pulse when PC increments from all-ones to 0

Behaviour:
- Reset (async, RESET_LOW=0): PC=0, MOTOR=0, sel=0, link=0, link_valid=0, state=RUN, tick/wait counters=0, WAIT_BUSY=0, PC_WRAP=0. Release takes effect at the next CLK edge; reset during WAIT aborts the wait.
- Execution: one instruction per cycle in RUN. Operand fields are taken from the LSBs.
- Opcodes:
  0 WAIT n: n = operand[WAIT_W-1:0]. n=0 behaves as NOP (PC+1). n>0 enters WAIT; PC is held. The instruction occupies exactly 1 + n*PRESCALE cycles, then PC+1.
  1 OUT: MOTOR <= operand[MOTOR_N-1:0]; PC+1. MOTOR changes at the executing edge.
  2 JMP a: PC <= operand[ADDR_W-1:0].
  3 JSET a: if SENSOR[sel]=1 then PC <= a, else PC+1.
  4 JCLR a: if SENSOR[sel]=0 then PC <= a, else PC+1.
  5 SEL s: sel <= operand[clog2(SENSOR_N)-1:0]; PC+1. If s >= SENSOR_N, sel <= 0.
  6 CALL a: link <= PC+1 (mod 2^ADDR_W); link_valid <= 1; PC <= a. A second CALL overwrites link (single level).
  7 RET: if link_valid then PC <= link and link_valid <= 0; otherwise NOP (PC+1).
- Sensor conditions are sampled on the edge that executes the jump. A JSET/JCLR immediately after SEL uses the new sel.
- FSM: RUN -> WAIT on WAIT with n>0. In WAIT, the prescaler counts 0..PRESCALE-1; each wrap decrements the remaining count. When the count reaches 0: WAIT -> RUN and PC+1 on the same edge. MEM_DATA is ignored while in WAIT; the operand is latched at entry.
- Width rules: PC arithmetic is modulo 2^ADDR_W. Wrap 2^ADDR_W-1 -> 0 is legal and pulses PC_WRAP for one cycle; jumps never pulse it.
- ENABLE=0: PC, MOTOR, sel, link, FSM state and both wait counters hold; PC_WRAP=0. Resuming continues exactly where execution left off.

Optional Feature:
SENSOR_SYNC_EN: when defined, SENSOR passes through a 2-flop synchroniser (reset to 0) before condition evaluation, adding 2 cycles of sensor latency. When undefined, SENSOR is used directly; the source must then be synchronous to CLK.

Decomposition:
- Shared package robot_cpu_pkg: opcode enum (OP_WAIT, OP_OUT, OP_JMP, OP_JSET, OP_JCLR, OP_SEL, OP_CALL, OP_RET), FSM state typedef (ST_RUN, ST_WAIT), opcode width constant 3.
- One sub-module: robot_wait_timer (prescaler + down-counter; inputs start, n, enable; output done).

Test Plan:
- Reset mid-WAIT: assert RESET_LOW=0 during WAIT 5 -> MEM_ADDR=0, MOTOR=0, WAIT_BUSY=0 immediately (asynchronously).
- Timing, PRESCALE=4: OUT 0b1010 at addr 0, WAIT 3 at addr 1 -> MOTOR=1010 after edge 1; MEM_ADDR=1 for 13 cycles, then 2; WAIT_BUSY high for 12 cycles. WAIT 0 -> 1 cycle.
- Conditional jumps: SEL 2, then JSET 0x20 with SENSOR=0100 -> PC=0x20. Same program with SENSOR=0000 -> PC+1. JCLR gives the inverse results. SEL 7 with SENSOR_N=4 -> sel=0.
- Call/return: CALL 0x10 at addr 5 -> PC=0x10; RET -> PC=6. A second RET -> PC+1 (NOP). Nested CALL overwrites link.
- Wrap and pause: NOP-equivalent WAIT 0 at 63 with ADDR_W=6 -> PC=0, PC_WRAP=1 for 1 cycle. ENABLE=0 for 10 cycles mid-WAIT -> total duration extended by exactly 10.
- SENSOR_SYNC_EN defined: sensor rising edge -> JSET sees it 2 cycles later than in the undefined build.
